// File: rtl/avalon_gpio_pkg.sv
// avalon_gpio_pkg
//   Shared constants for the Avalon-MM GPIO bank:
//   - register word offsets on the 3-bit address bus
//   - edge-type and irq-mode parameter encodings
//   - width helper for the post-reset arm counter
package avalon_gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  // The arm counter must hold the value stages+1 and then saturate there.
  function automatic int arm_cnt_w(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/avalon_gpio_bank_if.sv
// avalon_gpio_bank_if
//   Avalon-MM slave bus of the GPIO bank.
//   address    : word address of the register
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (bits above the GPIO width are ignored)
//   readdata   : registered read data, latency 1
//
//   Handshake: a write is accepted on every clk edge where chipselect=1 and
//   write_n=0 (no wait states). Reads need no strobe: readdata at edge t+1
//   always reflects the register addressed at edge t, sampled before any
//   write landing on that same edge.
interface avalon_gpio_bank_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
//   Input path of the GPIO bank: SYNC_STAGES-deep synchroniser, one
//   previous-sample flop, post-reset arm counter and per-bit edge detect.
//   clk, reset_n : clock, asynchronous active-low reset
//   gpio_in      : asynchronous pad inputs
//   dir          : direction register (1 = output, not detected)
//   sync_in      : synchronised inputs
//   edge_pulse   : one-cycle pulse per bit on a qualifying edge
module gpio_sync_edge
  import avalon_gpio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int              CW      = arm_cnt_w(SYNC_STAGES);
  localparam logic [CW-1:0]   ARM_MAX = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    arm_q, arm_d;
  logic             armed;
  logic [WIDTH-1:0] raw_edge;

  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign prev_d  = sync_in;

  // Until the chain and prev flop have been refilled from the pads, sync_in
  // and prev_in disagree only because of their reset values; stay blind.
  assign armed = (arm_q == ARM_MAX);
  assign arm_d = armed ? arm_q : arm_q + 1'b1;

  always_comb begin
    raw_edge = sync_in & ~prev_q;
    if (EDGE_TYPE == EDGE_FALLING) begin
      raw_edge = ~sync_in & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      raw_edge = sync_in ^ prev_q;
    end
  end

  assign edge_pulse = armed ? (raw_edge & ~dir) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/avalon_gpio_bank.sv
// avalon_gpio_bank
//   Parametrised Avalon-MM GPIO bank with per-bit direction, atomic set /
//   clear writes, synchronised inputs with edge capture and a maskable irq.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n,
//                  writedata, readdata)
//   gpio_in      : asynchronous pad inputs
//   gpio_out     : output data register
//   gpio_oe      : output enables (direction register, 1 = output)
//   irq          : interrupt, active high
module avalon_gpio_bank
  import avalon_gpio_pkg::*;
#(
  parameter int          WIDTH       = 10,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter int          IRQ_MODE    = IRQ_EDGE
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_gpio_bank_if.slave   bus,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic [WIDTH-1:0]    gpio_oe,
  output logic                irq
);

  localparam logic [WIDTH-1:0] OUT_RST = OUT_RESET[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_RST = DIR_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] sync_in, edge_pulse;
  logic [WIDTH-1:0] wdata, w1c, rd_val;
  logic             wr;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .gpio_in    (gpio_in),
    .dir        (dir_q),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:    out_d  = wdata;
        ADDR_DIR:     dir_d  = wdata;
        ADDR_IRQMASK: mask_d = wdata;
        ADDR_EDGECAP: w1c    = wdata;
        ADDR_OUTSET:  out_d  = out_q | wdata;
        ADDR_OUTCLR:  out_d  = out_q & ~wdata;
        default:      ;
      endcase
    end
    // A fresh edge beats a same-cycle clear so no event is lost.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_pulse;
  end

  // Read mux uses current register values, i.e. pre-write at this edge.
  always_comb begin
    rd_val = '0;
    case (bus.address)
      ADDR_DATA:    rd_val = (out_q & dir_q) | (sync_in & ~dir_q);
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = mask_q;
      ADDR_EDGECAP: rd_val = edge_cap_q;
      default:      rd_val = '0;
    endcase
    readdata_d = 32'(rd_val);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= OUT_RST;
      dir_q      <= DIR_RST;
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign gpio_out     = out_q;
  assign gpio_oe      = dir_q;
  assign irq = (IRQ_MODE == IRQ_LEVEL) ? |(sync_in & ~dir_q & mask_q)
                                       : |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_avalon_gpio_bank.sv
// tb_avalon_gpio_bank
//   Directed bench for avalon_gpio_bank with WIDTH=10, OUT_RESET=0x155,
//   SYNC_STAGES=2, rising-edge capture and edge-based irq.
module tb_avalon_gpio_bank;

  logic       clk;
  logic       reset_n;
  logic [9:0] gpio_in;
  logic [9:0] gpio_out;
  logic [9:0] gpio_oe;
  logic       irq;

  avalon_gpio_bank_if bus_if ();

  avalon_gpio_bank #(
    .WIDTH       (10),
    .OUT_RESET   (32'h155),
    .DIR_RESET   (32'hFFFF_FFFF),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .IRQ_MODE    (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] rd);
    @(negedge clk);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(posedge clk);
    #1;
    rd = bus_if.readdata;
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    exp_q.push_back(exp);
    bus_read(addr, rd);
    check(name, rd, exp_q.pop_front());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [9:0]  exp_out;
    logic [9:0]  exp_oe;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 3'd0, 32'h0F0,       32'h0,   10'h0F0, 10'h3FF};
    vecs[1]  = '{1'b1, 3'd4, 32'h003,       32'h0,   10'h0F3, 10'h3FF};
    vecs[2]  = '{1'b1, 3'd5, 32'h030,       32'h0,   10'h0C3, 10'h3FF};
    vecs[3]  = '{1'b0, 3'd4, 32'h0,         32'h0,   10'h0C3, 10'h3FF};
    vecs[4]  = '{1'b0, 3'd5, 32'h0,         32'h0,   10'h0C3, 10'h3FF};
    vecs[5]  = '{1'b0, 3'd0, 32'h0,         32'h0C3, 10'h0C3, 10'h3FF};
    vecs[6]  = '{1'b1, 3'd6, 32'h3FF,       32'h0,   10'h0C3, 10'h3FF};
    vecs[7]  = '{1'b0, 3'd6, 32'h0,         32'h0,   10'h0C3, 10'h3FF};
    vecs[8]  = '{1'b0, 3'd7, 32'h0,         32'h0,   10'h0C3, 10'h3FF};
    vecs[9]  = '{1'b1, 3'd1, 32'h300,       32'h0,   10'h0C3, 10'h300};
    vecs[10] = '{1'b0, 3'd1, 32'h0,         32'h300, 10'h0C3, 10'h300};
    vecs[11] = '{1'b1, 3'd2, 32'h2A5,       32'h0,   10'h0C3, 10'h300};
    vecs[12] = '{1'b0, 3'd2, 32'h0,         32'h2A5, 10'h0C3, 10'h300};
    vecs[13] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0,   10'h3FF, 10'h300};
    vecs[14] = '{1'b0, 3'd0, 32'h0,         32'h300, 10'h3FF, 10'h300};
    vecs[15] = '{1'b0, 3'd3, 32'h0,         32'h0,   10'h3FF, 10'h300};
    vecs[16] = '{1'b1, 3'd7, 32'h155,       32'h0,   10'h3FF, 10'h300};

    // ---- reset state ----
    reset_n          = 1'b0;
    gpio_in          = '0;
    bus_if.address   = '0;
    bus_if.writedata = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_gpio_out", 32'(gpio_out), 32'h155);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h3FF);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", bus_if.readdata, 32'h0);
    reset_n = 1'b1;
    read_check("rst_rd_data", 3'd0, 32'h155);

    // ---- register map vectors ----
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        exp_q.push_back(vecs[i].exp_rd);
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd", i), rd, exp_q.pop_front());
      end
      check($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
    end

    // ---- input sync latency on mixed direction ----
    // dir=0x300, gpio_out=0x3FF, mask=0x2A5
    @(negedge clk);
    gpio_in = 10'h0AA;
    @(posedge clk);
    read_check("sync_early", 3'd0, 32'h300);
    read_check("sync_data", 3'd0, 32'h3AA);
    check("mixed_irq", 32'(irq), 32'h1);
    read_check("mixed_edgecap", 3'd3, 32'h0AA);
    bus_write(3'd3, 32'h0FF);
    check("mixed_w1c_irq", 32'(irq), 32'h0);
    read_check("mixed_w1c_cap", 3'd3, 32'h0);

    // ---- rising edge on bit 0, latency and W1C ----
    @(negedge clk);
    gpio_in = 10'h000;
    repeat (4) @(posedge clk);
    read_check("fall_ignored", 3'd3, 32'h0);
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h001);
    check("edge_irq_idle", 32'(irq), 32'h0);
    @(negedge clk);
    gpio_in = 10'h001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("edge_irq_2edges", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("edge_irq_3edges", 32'(irq), 32'h1);
    read_check("edge_cap", 3'd3, 32'h001);
    bus_write(3'd3, 32'h001);
    check("w1c_irq", 32'(irq), 32'h0);
    read_check("w1c_cap", 3'd3, 32'h0);

    // ---- W1C colliding with a new edge: the set wins ----
    @(negedge clk);
    gpio_in = 10'h000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpio_in = 10'h001;
    @(posedge clk);
    @(posedge clk);
    bus_write(3'd3, 32'h001);
    check("collide_irq", 32'(irq), 32'h1);
    read_check("collide_cap", 3'd3, 32'h001);

    // ---- asynchronous reset mid-run, then arm suppression ----
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    gpio_in = 10'h3FF;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_gpio_out", 32'(gpio_out), 32'h155);
    check("arst_gpio_oe", 32'(gpio_oe), 32'h3FF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_write(3'd1, 32'h0);
    read_check("arst_mask", 3'd2, 32'h0);
    bus_write(3'd2, 32'h3FF);
    repeat (3) @(posedge clk);
    read_check("arm_edgecap", 3'd3, 32'h0);
    check("arm_irq", 32'(irq), 32'h0);
    read_check("arm_data", 3'd0, 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
